// File: rtl/params_pkg.sv
// Shared constants and types for the AXI-Stream byte path.
package params_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned AXIS_BYTE_W = 8;

  typedef struct packed {
    logic                   last;
    logic [AXIS_BYTE_W-1:0] data;
  } axis_byte_t;

endpackage

// File: rtl/axi_stream_if.sv
// AXI-Stream bundle carrying 32-bit beats with tlast.
interface axi_stream_if;
  import params_pkg::*;

  logic                   tvalid;
  logic                   tready;
  logic [AXIS_DATA_W-1:0] tdata;
  logic                   tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Pointers carry one extra bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == PW'(DEPTH));
  assign head  = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/axi_stream_sink.sv
// AXI-Stream slave that buffers the low byte and tlast of each beat and
// presents them on a byte-wide valid/ready port; tracks frames and padding.
module axi_stream_sink
  import params_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  axi_stream_if.slave            axis,
  output logic [AXIS_BYTE_W-1:0] data_out,
  output logic                   data_out_last,
  output logic                   data_out_valid,
  input  logic                   data_out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       frame_count,
  output logic                   pad_err,
  input  logic                   clr_status
);
  axis_byte_t wr_byte;
  axis_byte_t head;
  logic       push;
  logic       pop;
  logic       empty;
  logic       full;

  assign wr_byte = '{last: axis.tlast, data: axis.tdata[AXIS_BYTE_W-1:0]};

  // tready comes straight from the registered pointers, never from tvalid.
  assign axis.tready = !full;
  assign push        = axis.tvalid && axis.tready;
  assign pop         = data_out_valid && data_out_ready;

  assign data_out_valid = !empty;
  assign data_out       = head.data;
  // Gated so the flag reads 0 after reset even though storage is not cleared.
  assign data_out_last  = data_out_valid && head.last;

  sync_fifo #(
    .WIDTH ($bits(axis_byte_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (wr_byte),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full),
    .level     (fifo_level)
  );

  // Saturating frame counter; clr_status wins over a coincident frame end.
  always_ff @(posedge clk) begin
    if (!reset_n || clr_status) begin
      frame_count <= '0;
    end else if (push && axis.tlast && (frame_count != '1)) begin
      frame_count <= frame_count + 1'b1;
    end
  end

  // Sticky flag for beats carrying non-zero data above the low byte.
  always_ff @(posedge clk) begin
    if (!reset_n || clr_status) begin
      pad_err <= 1'b0;
    end else if (push && (axis.tdata[AXIS_DATA_W-1:AXIS_BYTE_W] != '0)) begin
      pad_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_stream_sink.sv
// Directed bench for axi_stream_sink with a queue-based reference model.
module tb_axi_stream_sink;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             data_out_ready = 1'b0;
  logic             clr_status = 1'b0;
  logic [7:0]       data_out;
  logic             data_out_last;
  logic             data_out_valid;
  logic [3:0]       fifo_level;
  logic [CNT_W-1:0] frame_count;
  logic             pad_err;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // reference model state
  logic [8:0]  mq[$];
  int unsigned m_frames = 0;
  logic        m_pad = 1'b0;
  logic        m_push;
  logic        m_pop;
  logic [8:0]  m_dummy;

  axi_stream_if axis();

  always #5 clk = ~clk;

  axi_stream_sink #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .axis           (axis),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .fifo_level     (fifo_level),
    .frame_count    (frame_count),
    .pad_err        (pad_err),
    .clr_status     (clr_status)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    axis.tvalid = 1'b1;
    axis.tdata  = d;
    axis.tlast  = l;
    step(1);
  endtask

  // Model: a byte queue of capacity DEPTH, frame count and sticky pad flag.
  initial begin
    forever begin
      @(posedge clk);
      m_push = axis.tvalid && (mq.size() < DEPTH);
      m_pop  = (mq.size() > 0) && data_out_ready;
      if (!reset_n) begin
        mq.delete();
        m_frames = 0;
        m_pad = 1'b0;
      end else begin
        if (m_pop) m_dummy = mq.pop_front();
        if (m_push) mq.push_back({axis.tlast, axis.tdata[7:0]});
        if (clr_status) begin
          m_frames = 0;
          m_pad = 1'b0;
        end else if (m_push) begin
          if (axis.tlast && m_frames < CNT_MAX) m_frames++;
          if (axis.tdata[31:8] != 24'h0) m_pad = 1'b1;
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("tready", 32'(axis.tready), 32'(mq.size() < DEPTH));
        chk("valid", 32'(data_out_valid), 32'(mq.size() > 0));
        chk("level", 32'(fifo_level), 32'(mq.size()));
        chk("frame_count", 32'(frame_count), 32'(m_frames));
        chk("pad_err", 32'(pad_err), 32'(m_pad));
        if (mq.size() > 0) begin
          chk("data_out", 32'(data_out), 32'(mq[0][7:0]));
          chk("data_out_last", 32'(data_out_last), 32'(mq[0][8]));
        end
      end
    end
  end

  initial begin
    axis.tvalid = 1'b0;
    axis.tdata  = '0;
    axis.tlast  = 1'b0;

    // reset state
    step(2);
    reset_n = 1'b1;
    chk_en  = 1;
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_tready", 32'(axis.tready), 32'd1);
    chk("rst_valid", 32'(data_out_valid), 32'd0);
    chk("rst_last", 32'(data_out_last), 32'd0);
    chk("rst_frames", 32'(frame_count), 32'd0);
    chk("rst_pad", 32'(pad_err), 32'd0);

    // three-byte frame with consumer ready
    data_out_ready = 1'b1;
    beat(32'h11, 1'b0);
    chk("lat_data", 32'(data_out), 32'h11);
    chk("lat_valid", 32'(data_out_valid), 32'd1);
    beat(32'h22, 1'b0);
    beat(32'h33, 1'b1);
    chk("last_data", 32'(data_out), 32'h33);
    chk("last_flag", 32'(data_out_last), 32'd1);
    chk("frame1", 32'(frame_count), 32'd1);
    axis.tvalid = 1'b0;
    step(2);

    // fill with consumer stalled: only DEPTH of 10 accepted
    data_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) beat(32'hA0 + 32'(i), 1'b0);
    axis.tvalid = 1'b0;
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_tready", 32'(axis.tready), 32'd0);
    data_out_ready = 1'b1;
    step(1);
    chk("unfull_tready", 32'(axis.tready), 32'd1);
    chk("unfull_level", 32'(fifo_level), 32'd7);
    chk("unfull_head", 32'(data_out), 32'hA1);
    step(8);
    chk("drained", 32'(data_out_valid), 32'd0);

    // fill, then random traffic on both sides across pointer wrap
    data_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) begin
      data_out_ready = 1'($urandom_range(0, 1));
      axis.tvalid    = 1'($urandom_range(0, 1));
      axis.tdata     = 32'($urandom_range(0, 255));
      axis.tlast     = 1'($urandom_range(0, 1));
      step(1);
    end
    axis.tvalid    = 1'b0;
    data_out_ready = 1'b1;
    step(10);
    chk("rand_drained", 32'(fifo_level), 32'd0);

    // padding error and clear priority
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    data_out_ready = 1'b0;
    beat(32'h0000_0100, 1'b0);
    axis.tvalid = 1'b0;
    chk("pad_set", 32'(pad_err), 32'd1);
    chk("pad_byte", 32'(data_out), 32'h00);
    clr_status = 1'b1;
    beat(32'h55, 1'b1);
    clr_status = 1'b0;
    axis.tvalid = 1'b0;
    chk("clr_frames", 32'(frame_count), 32'd0);
    chk("clr_pad", 32'(pad_err), 32'd0);
    chk("clr_keeps_fifo", 32'(fifo_level), 32'd2);
    data_out_ready = 1'b1;
    step(3);

    // reset with bytes buffered
    data_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) beat(32'h60 + 32'(i), 1'b0);
    axis.tvalid = 1'b0;
    chk("pre_rst_level", 32'(fifo_level), 32'd5);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_valid", 32'(data_out_valid), 32'd0);
    chk("mid_rst_tready", 32'(axis.tready), 32'd1);
    data_out_ready = 1'b1;
    beat(32'h77, 1'b1);
    chk("post_rst_data", 32'(data_out), 32'h77);
    beat(32'h78, 1'b0);
    axis.tvalid = 1'b0;
    chk("post_rst_frames", 32'(frame_count), 32'd1);
    step(3);

    // frame counter saturation
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    for (int i = 0; i < 15; i++) beat(32'(i), 1'b1);
    axis.tvalid = 1'b0;
    chk("sat_15", 32'(frame_count), 32'd15);
    beat(32'hF0, 1'b1);
    beat(32'hF1, 1'b1);
    axis.tvalid = 1'b0;
    chk("sat_hold", 32'(frame_count), 32'd15);
    step(3);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
